// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants, FSM encoding and pack/unpack helpers
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ALIGN = 3'd2,
    S_ARITH = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } fp_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
  } fp_unpacked_t;

  // Zero exponent flushes the operand (denormals included) to a zero mantissa.
  function automatic fp_unpacked_t unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.man  = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    return u;
  endfunction

  function automatic logic [31:0] pack(input logic sign, input logic [EXP_W-1:0] exp,
                                       input logic [MAN_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_shift1.sv
// rtl/fp_shift1.sv - one-bit bidirectional mantissa shifter with paired counter adjust
module fp_shift1 (
  input  logic [24:0] man,
  input  logic [8:0]  cnt,
  input  logic        left,
  input  logic        inc,
  output logic [24:0] man_o,
  output logic [8:0]  cnt_o
);

  assign man_o = left ? {man[23:0], 1'b0} : {1'b0, man[24:1]};
  assign cnt_o = inc ? cnt + 9'd1 : cnt - 9'd1;

endmodule

// File: rtl/float_sub_seq.sv
// rtl/float_sub_seq.sv - serial IEEE-754 single-precision subtractor, result = a - b
module float_sub_seq
  import fp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  fp_state_t state, state_nx;

  logic [31:0]  opa, opb;
  logic         sx, sy;
  logic [8:0]   ex, diff;
  logic [24:0]  mx, my;
  fp_unpacked_t ua, ub;
  logic         swap;

  logic [24:0]  sh_man, sh_man_o;
  logic [8:0]   sh_cnt, sh_cnt_o;
  logic         sh_left, sh_inc;
  logic         align_exit, norm_exit, accept;

  assign ua     = unpack(opa);
  assign ub     = unpack(opb);
  assign swap   = (ub.exp > ua.exp) || ((ub.exp == ua.exp) && (ub.man > ua.man));
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // The single shifter serves Y alignment (diff counts down) and normalisation (exp tracks).
  always_comb begin
    sh_man  = mx;
    sh_cnt  = ex;
    sh_left = ~mx[24];
    sh_inc  = mx[24];
    if (state == S_ALIGN) begin
      sh_man  = my;
      sh_cnt  = diff;
      sh_left = 1'b0;
      sh_inc  = 1'b0;
    end
  end

  fp_shift1 u_shift (
    .man   (sh_man),
    .cnt   (sh_cnt),
    .left  (sh_left),
    .inc   (sh_inc),
    .man_o (sh_man_o),
    .cnt_o (sh_cnt_o)
  );

  assign align_exit = (diff == 9'd0) || (my == 25'd0);
  assign norm_exit  = (mx == 25'd0)
                    || (mx[24] && (sh_cnt_o >= 9'(EXP_MAX)))
                    || (!mx[24] && mx[23])
                    || (!mx[24] && !mx[23] && (ex <= 9'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_ALIGN;
      S_ALIGN: if (align_exit) state_nx = S_ARITH;
      S_ARITH: state_nx = S_NORM;
      S_NORM:  if (norm_exit) state_nx = S_DONE;
      S_DONE:  state_nx = accept ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      sx       <= 1'b0;
      sy       <= 1'b0;
      ex       <= '0;
      diff     <= '0;
      mx       <= '0;
      my       <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        opa <= a;
        opb <= {~b[31], b[30:0]};
      end
      case (state)
        S_LOAD: begin
          sx   <= swap ? ub.sign : ua.sign;
          sy   <= swap ? ua.sign : ub.sign;
          ex   <= swap ? {1'b0, ub.exp} : {1'b0, ua.exp};
          mx   <= swap ? {1'b0, ub.man} : {1'b0, ua.man};
          my   <= swap ? {1'b0, ua.man} : {1'b0, ub.man};
          diff <= swap ? {1'b0, ub.exp} - {1'b0, ua.exp} : {1'b0, ua.exp} - {1'b0, ub.exp};
        end
        S_ALIGN: begin
          if (!align_exit) begin
            if (diff >= 9'd25) begin
              my   <= '0;
              diff <= '0;
            end else begin
              my   <= sh_man_o;
              diff <= sh_cnt_o;
            end
          end
        end
        S_ARITH: begin
          // Swap guarantees mx >= my, so the difference never goes negative.
          if (sx == sy) mx <= mx + my;
          else          mx <= mx - my;
          if ((sx != sy) && (mx == my)) sx <= 1'b0;
        end
        S_NORM: begin
          if (mx == 25'd0) begin
            result   <= '0;
            overflow <= 1'b0;
          end else if (mx[24]) begin
            mx <= sh_man_o;
            ex <= sh_cnt_o;
            if (sh_cnt_o >= 9'(EXP_MAX)) begin
              result   <= {sx, 8'hFF, 23'd0};
              overflow <= 1'b1;
            end
          end else if (mx[23]) begin
            result   <= pack(sx, ex[7:0], mx[22:0]);
            overflow <= 1'b0;
          end else begin
            mx <= sh_man_o;
            ex <= sh_cnt_o;
            if (ex <= 9'd1) begin
              result   <= '0;
              overflow <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
